// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Imported by the FSM top and the ALU function decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXE  = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_REG    = 2'b01;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States whose exit back to FETCH completes (retires) an instruction.
    function automatic logic is_terminal(input state_t s);
        return (s == S_MEMWB) || (s == S_MEMWRITE) || (s == S_ALUWB) ||
               (s == S_BRANCH) || (s == S_ADDIWB) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation; valid drops for unsupported functs.
module alu_decoder
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W       = 6,
    parameter int ALU_CTRL_W = 4
) (
    input  logic [OP_W-1:0]       funct,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  valid
);

    always_comb begin
        alu_control = '0;
        valid       = 1'b1;
        case (funct)
            OP_W'(FN_ADD): alu_control = ALU_CTRL_W'(ALU_ADD);
            OP_W'(FN_SUB): alu_control = ALU_CTRL_W'(ALU_SUB);
            OP_W'(FN_AND): alu_control = ALU_CTRL_W'(ALU_AND);
            OP_W'(FN_OR):  alu_control = ALU_CTRL_W'(ALU_OR);
            OP_W'(FN_SLT): alu_control = ALU_CTRL_W'(ALU_SLT);
            default:       valid       = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM with memory-ready handshake, jump, optional bne,
// sticky illegal-opcode trap and a retired-instruction counter.
//
//  state      | meaning
//  FETCH    0 | read instruction at PC, PC+4 (waits for mem_ready)
//  DECODE   1 | dispatch on opcode, precompute branch target
//  MEMADR   2 | A + sign-extended immediate
//  MEMREAD  3 | load data read (waits for mem_ready)
//  MEMWB    4 | MDR -> rt
//  MEMWRITE 5 | store data write (waits for mem_ready)
//  EXECUTE  6 | R-type ALU operation from funct
//  ALUWB    7 | ALUOut -> rd
//  BRANCH   8 | compare A/B, conditional PC update
//  ADDIEXE  9 | A + sign-extended immediate
//  ADDIWB  10 | ALUOut -> rt
//  JUMP    11 | PC <- jump target
//  TRAP    12 | undecodable instruction, held until reset
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W       = 6,
    parameter int ALU_CTRL_W = 4,
    parameter int CNT_W      = 32,
    parameter int EN_BNE     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OP_W-1:0]       op,
    input  logic [OP_W-1:0]       funct,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  branch,
    output logic                  branch_ne,
    output logic                  iord,
    output logic                  mem_write,
    output logic                  mem_req,
    output logic                  ir_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            pc_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal_op,
    output logic [CNT_W-1:0]      instr_retired,
    output logic [3:0]            state_o
);

    localparam bit BNE_ON = (EN_BNE != 0);

    state_t                state, state_next;
    logic                  op_rtype, op_lw, op_sw, op_beq, op_bne, op_addi, op_j;
    logic [ALU_CTRL_W-1:0] dec_alu_control;
    logic                  dec_valid;

    assign op_rtype = (op == OP_W'(OP_RTYPE));
    assign op_lw    = (op == OP_W'(OP_LW));
    assign op_sw    = (op == OP_W'(OP_SW));
    assign op_beq   = (op == OP_W'(OP_BEQ));
    assign op_bne   = BNE_ON && (op == OP_W'(OP_BNE));
    assign op_addi  = (op == OP_W'(OP_ADDI));
    assign op_j     = (op == OP_W'(OP_J));

    alu_decoder #(
        .OP_W       (OP_W),
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_dec (
        .funct       (funct),
        .alu_control (dec_alu_control),
        .valid       (dec_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (op_rtype)              state_next = S_EXECUTE;
                else if (op_lw || op_sw)   state_next = S_MEMADR;
                else if (op_addi)          state_next = S_ADDIEXE;
                else if (op_beq || op_bne) state_next = S_BRANCH;
                else if (op_j)             state_next = S_JUMP;
                else                       state_next = S_TRAP;
            end
            S_MEMADR:   state_next = op_sw ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECUTE:  state_next = dec_valid ? S_ALUWB : S_TRAP;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_ADDIEXE:  state_next = S_ADDIWB;
            S_ADDIWB:   state_next = S_FETCH;
            S_JUMP:     state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    // Gating on rst keeps FETCH's strobes from leaking out while held in reset.
    always_comb begin
        pc_write    = 1'b0;
        branch      = 1'b0;
        branch_ne   = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        mem_req     = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_REG;
        pc_src      = PCSRC_ALU;
        alu_control = '0;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    mem_req     = 1'b1;
                    alu_src_b   = SRCB_FOUR;
                    alu_control = ALU_CTRL_W'(ALU_ADD);
                    ir_write    = mem_ready;
                    pc_write    = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b   = SRCB_IMM_SH;
                    alu_control = ALU_CTRL_W'(ALU_ADD);
                end
                S_MEMADR, S_ADDIEXE: begin
                    alu_src_a   = SRCA_REG;
                    alu_src_b   = SRCB_IMM;
                    alu_control = ALU_CTRL_W'(ALU_ADD);
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a   = SRCA_REG;
                    alu_control = dec_alu_control;
                end
                S_ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a   = SRCA_REG;
                    alu_control = ALU_CTRL_W'(ALU_SUB);
                    pc_src      = PCSRC_ALUOUT;
                    branch      = op_beq;
                    branch_ne   = op_bne;
                end
                S_ADDIWB:   reg_write = 1'b1;
                S_JUMP: begin
                    pc_src   = PCSRC_JUMP;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_op    <= 1'b0;
            instr_retired <= '0;
        end else begin
            if (state_next == S_TRAP)
                illegal_op <= 1'b1;
            if (is_terminal(state) && (state_next == S_FETCH))
                instr_retired <= instr_retired + CNT_W'(1);
        end
    end

    assign state_o = state;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Parametrised multicycle MIPS control unit with a built-in state machine.
- Generates every datapath strobe for a shared instruction/data memory multicycle core.
- Adds over the previous control unit: a memory-ready handshake (variable memory latency), optional bne support, jump support, an illegal-opcode trap and a retired-instruction counter.
- Sits between the instruction register (op/funct fields) and the datapath muxes, register file, memory and PC enable logic.

Parameters:
- OP_W, 6, width of the opcode and funct fields.
- ALU_CTRL_W, 4, width of alu_control.
- CNT_W, 32, width of the retired-instruction counter.
- EN_BNE, 1, 1 = decode bne (opcode 000101); 0 = bne is treated as illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op  in  OP_W  instruction opcode field (instr[31:26]).
- funct  in  OP_W  R-type function field (instr[5:0]).
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  unconditional PC update.
- branch  out  1  beq condition PC update.
- branch_ne  out  1  bne condition PC update (0 when EN_BNE=0).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write strobe.
- mem_req  out  1  memory access requested this cycle.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  register destination select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = A register.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_control  out  ALU_CTRL_W  ALU operation.
- illegal_op  out  1  sticky flag: undecodable opcode/funct.
- instr_retired  out  CNT_W  count of completed instructions.
- state_o  out  4  current state, for debug.

Behaviour:
- rst low (asynchronous assert):
  - state returns to FETCH.
  - illegal_op = 0 and instr_retired = 0.
  - All strobe and select outputs are forced to 0 while rst is low.
- Release is synchronous; the first active cycle is FETCH.
- Outputs are Moore, decoded from state. Exceptions: pc_write and ir_write in FETCH are qualified by mem_ready.
- ALU encodings: ADD=0010, SUB=0110, AND=0000, OR=0001, SLT=0111.
- States and transitions:
  - FETCH (0): mem_req=1, iord=0, alu_src_a=00, alu_src_b=01, ADD, pc_src=00; ir_write=pc_write=mem_ready. Stay while !mem_ready, else go to DECODE.
  - DECODE (1): alu_src_a=00, alu_src_b=11, ADD (precomputes the branch target).
    - R-type → EXECUTE; lw/sw → MEMADR; addi → ADDIEXE; beq/bne → BRANCH; j → JUMP.
    - Any other opcode → TRAP.
  - MEMADR (2): alu_src_a=01, alu_src_b=10, ADD. lw → MEMREAD; sw → MEMWRITE.
  - MEMREAD (3): mem_req=1, iord=1. Hold until mem_ready, then → MEMWB.
  - MEMWB (4): reg_dst=0, mem_to_reg=1, reg_write=1 → FETCH.
  - MEMWRITE (5): mem_req=1, iord=1, mem_write=1. Hold until mem_ready, then → FETCH.
  - EXECUTE (6): alu_src_a=01, alu_src_b=00, alu_control from funct.
    - Funct codes: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
    - Any other funct → TRAP; otherwise → ALUWB.
  - ALUWB (7): reg_dst=1, mem_to_reg=0, reg_write=1 → FETCH.
  - BRANCH (8): alu_src_a=01, alu_src_b=00, SUB, pc_src=01; branch=1 for beq, branch_ne=1 for bne → FETCH.
  - ADDIEXE (9): alu_src_a=01, alu_src_b=10, ADD → ADDIWB.
  - ADDIWB (10): reg_dst=0, mem_to_reg=0, reg_write=1 → FETCH.
  - JUMP (11): pc_src=10, pc_write=1 → FETCH.
  - TRAP (12): illegal_op set; all strobes 0. Stays here until reset.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, addi=001000, j=000010.
- op and funct are sampled from the IR, which is stable from DECODE to retirement. The FSM does not register them.
- instr_retired increments by 1 on every transition into FETCH from a terminal state. Terminal states: MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP. The counter wraps modulo 2^CNT_W.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Reset asserted mid-instruction aborts it; no strobe survives into the reset.
- Instruction cycle counts (mem_ready=1): lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3. Each memory wait cycle adds 1.

Decomposition:
- Package mc_ctrl_pkg: state_t enum, opcode and funct localparams, ALU control encodings, select-encoding localparams.
- Sub-module alu_decoder (funct → alu_control plus a valid flag), used in EXECUTE.

Test Plan:
- Reset: rst=0 mid-MEMREAD → state_o=0, all outputs 0, instr_retired=0. After release, first cycle is FETCH with mem_ready=1 → ir_write=1, pc_write=1.
- lw, mem_ready=1 throughout → states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_retired=1.
- sw with mem_ready low for 3 cycles in MEMWRITE → mem_write held for 4 cycles; exit on the ready cycle; 7 cycles total.
- R-type funct 100010 → alu_control=0110 in EXECUTE, reg_dst=1 in ALUWB. Then beq → branch=1, pc_src=01; then bne with EN_BNE=1 → branch_ne=1.
- j → pc_src=10, pc_write=1 in JUMP; addi → alu_src_b=10 then reg_write=1, reg_dst=0.
- op=111111 → TRAP; illegal_op=1 and remains 1 for 20 cycles; instr_retired unchanged. Separately, R-type funct 000000 → TRAP.
